// File: rtl/instr_fetch_if.sv
// Bundle of instruction-memory, redirect and decoder-side signals for the fetch unit.
// The master modport is the fetch unit; the slave modport is its environment.
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_data;
  logic        branch;
  logic [31:0] branch_target;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instruction, instr_pc,
    input  imem_valid, imem_data, branch, branch_target, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instruction, instr_pc,
    output imem_valid, imem_data, branch, branch_target, instr_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding memory request at a time and a 2-entry
// {word, address} buffer toward the decoder, with branch redirect and flush.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input logic           clock,
  input logic           reset,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FLUSH} state_t;

  state_t      state;
  state_t      state_next;
  state_t      reset_state;
  logic [31:0] pc;
  logic [31:0] word0, word1;
  logic [31:0] addr0, addr1;
  logic [1:0]  count;
  logic [1:0]  count_after_push;
  logic        push;
  logic        pop;

  assign push             = (state == WAIT) && bus.imem_valid && !bus.branch;
  assign pop              = (count != 2'd0) && bus.instr_ready;
  assign count_after_push = count + 2'd1 - {1'b0, pop};

  // A request already on the bus when reset hits must still have its response
  // swallowed, so reset parks in FLUSH unless that response arrives right now.
  always_comb begin
    reset_state = IDLE;
    if (state == REQ || ((state == WAIT || state == FLUSH) && !bus.imem_valid))
      reset_state = FLUSH;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.branch || count < 2'd2)
          state_next = REQ;
      end
      REQ: begin
        state_next = bus.branch ? FLUSH : WAIT;
      end
      WAIT: begin
        if (bus.imem_valid) begin
          if (bus.branch || count_after_push < 2'd2)
            state_next = REQ;
          else
            state_next = IDLE;
        end else if (bus.branch) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (bus.imem_valid)
          state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset)
      state <= reset_state;
    else
      state <= state_next;
  end

  // Branch wins over any same-cycle push or pop; otherwise the head shifts on pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc    <= RESET_PC;
      count <= 2'd0;
      word0 <= 32'h0;
      word1 <= 32'h0;
      addr0 <= 32'h0;
      addr1 <= 32'h0;
    end else if (bus.branch) begin
      pc    <= bus.branch_target;
      count <= 2'd0;
    end else begin
      if (push)
        pc <= pc + 32'(PC_STEP);
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            word0 <= bus.imem_data;
            addr0 <= pc;
          end else begin
            word1 <= bus.imem_data;
            addr1 <= pc;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          word0 <= word1;
          addr0 <= addr1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            word0 <= bus.imem_data;
            addr0 <= pc;
          end else begin
            word0 <= word1;
            addr0 <= addr1;
            word1 <= bus.imem_data;
            addr1 <= pc;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.imem_req    = (state == REQ);
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = (count != 2'd0);
  assign bus.instruction = (count != 2'd0) ? word0 : 32'h0;
  assign bus.instr_pc    = (count != 2'd0) ? addr0 : 32'h0;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a random-latency memory responder plus an
// in-order program-counter model of what the decoder and memory must observe.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] STEP     = 32'd4;

  logic clock;
  logic reset;
  instr_fetch_if bus();

  instr_fetch #(.RESET_PC(RESET_PC), .PC_STEP(4)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  bit          resp_pending;
  int          resp_delay;
  logic [31:0] resp_addr;
  logic [31:0] exp_pc;
  logic [31:0] next_req;
  int          ready_mode;
  int          branch_pct;
  int          reset_pml;
  int          lat_min, lat_max;
  bit          force_branch;
  logic [31:0] force_target;
  bit          branch_on_resp;
  bit          resp_branch_fired;
  logic [31:0] resp_target;
  int          force_reset_cycles;
  int          req_count, pop_count;
  bit          req_seen;
  logic [31:0] popped_q[$];

  // Memory contents are a fixed scramble of the address, so each word is traceable.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    req_seen = 1'b0;
    if (bus.instr_valid === 1'b1) begin
      check("head_pc", bus.instr_pc, exp_pc);
      check("head_word", bus.instruction, mem_word(exp_pc));
    end else begin
      check("empty_word", bus.instruction, 32'h0);
      check("empty_pc", bus.instr_pc, 32'h0);
    end
    if (bus.imem_req === 1'b1) begin
      check("one_outstanding", 32'(resp_pending), 32'd0);
      check("req_addr", bus.imem_addr, next_req);
      resp_pending = 1'b1;
      resp_addr    = bus.imem_addr;
      resp_delay   = $urandom_range(lat_max, lat_min);
      next_req     = next_req + STEP;
      req_count++;
      req_seen = 1'b1;
    end
  endtask

  task automatic apply_stimulus();
    logic        rdy, br, rst, vld;
    logic [31:0] tgt, dat;
    rst = 1'b0;
    if (force_reset_cycles > 0) begin
      rst = 1'b1;
      force_reset_cycles--;
    end else if (reset_pml > 0 && $urandom_range(999, 0) < reset_pml) begin
      rst = 1'b1;
    end
    vld = 1'b0;
    dat = $urandom;
    if (resp_pending) begin
      if (resp_delay == 0) begin
        vld          = 1'b1;
        dat          = mem_word(resp_addr);
        resp_pending = 1'b0;
      end else begin
        resp_delay--;
      end
    end
    case (ready_mode)
      0:       rdy = 1'b0;
      1:       rdy = 1'b1;
      default: rdy = ($urandom_range(99, 0) < 70);
    endcase
    br  = 1'b0;
    tgt = $urandom & 32'hFFFF_FFFC;
    if (force_branch) begin
      br           = 1'b1;
      tgt          = force_target;
      force_branch = 1'b0;
    end else if (branch_on_resp && vld) begin
      br                = 1'b1;
      tgt               = resp_target;
      branch_on_resp    = 1'b0;
      resp_branch_fired = 1'b1;
    end else if (branch_pct > 0 && $urandom_range(99, 0) < branch_pct) begin
      br = 1'b1;
    end
    // Reset beats branch beats pop; the decoder always sees addresses in order.
    if (rst) begin
      exp_pc   = RESET_PC;
      next_req = RESET_PC;
    end else if (br) begin
      exp_pc   = tgt;
      next_req = tgt;
    end else if (bus.instr_valid === 1'b1 && rdy) begin
      popped_q.push_back(bus.instr_pc);
      exp_pc = exp_pc + STEP;
      pop_count++;
    end
    reset             = rst;
    bus.imem_valid    = vld;
    bus.imem_data     = dat;
    bus.instr_ready   = rdy;
    bus.branch        = br;
    bus.branch_target = br ? tgt : $urandom;
  endtask

  task automatic cycle();
    @(negedge clock);
    check_output();
    apply_stimulus();
  endtask

  task automatic wait_req(input int bound);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!req_seen && n < bound);
    check("req_timeout", 32'(req_seen), 32'd1);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    bus.imem_valid = 1'b0;
    bus.imem_data = 32'h0;
    bus.instr_ready = 1'b0;
    bus.branch = 1'b0;
    bus.branch_target = 32'h0;
    exp_pc = RESET_PC;
    next_req = RESET_PC;
    ready_mode = 1;
    branch_pct = 0;
    reset_pml = 0;
    lat_min = 1;
    lat_max = 1;
    force_reset_cycles = 2;

    // Reset, then first request exactly one cycle after release.
    repeat (3) cycle();
    check("reset_req", 32'(bus.imem_req), 32'd0);
    check("reset_valid", 32'(bus.instr_valid), 32'd0);
    cycle();
    check("first_req", 32'(bus.imem_req), 32'd1);
    check("first_addr", bus.imem_addr, RESET_PC);
    cycle();
    cycle();
    check("latency1_valid", 32'(bus.instr_valid), 32'd1);

    // Streaming with a ready decoder delivers 0x0, 0x4, 0x8.
    n = 0;
    while (popped_q.size() < 3 && n < 40) begin
      cycle();
      n++;
    end
    check("stream_pops", 32'(popped_q.size() >= 3), 32'd1);
    if (popped_q.size() >= 3) begin
      check("stream_pc0", popped_q[0], 32'h0);
      check("stream_pc1", popped_q[1], 32'h4);
      check("stream_pc2", popped_q[2], 32'h8);
    end

    // Stalled decoder: exactly two fetches fill the buffer, then one pop refills one.
    ready_mode = 0;
    force_branch = 1'b1;
    force_target = 32'h0000_2000;
    cycle();
    req_count = 0;
    repeat (20) cycle();
    check("stall_reqs", 32'(req_count), 32'd2);
    check("stall_full", 32'(bus.instr_valid), 32'd1);
    check("stall_noreq", 32'(bus.imem_req), 32'd0);
    pop_count = 0;
    req_count = 0;
    ready_mode = 1;
    cycle();
    ready_mode = 0;
    repeat (10) cycle();
    check("pulse_pops", 32'(pop_count), 32'd1);
    check("pulse_reqs", 32'(req_count), 32'd1);

    // Branch while waiting; the late response must be discarded.
    ready_mode = 1;
    lat_min = 4;
    lat_max = 4;
    wait_req(20);
    force_branch = 1'b1;
    force_target = 32'h0000_0100;
    cycle();
    lat_min = 1;
    lat_max = 1;
    wait_req(20);
    check("flush_addr", bus.imem_addr, 32'h0000_0100);
    check("flush_empty", 32'(bus.instr_valid), 32'd0);

    // Branch in the same cycle as a response.
    lat_min = 2;
    lat_max = 2;
    resp_target = 32'h0000_0300;
    resp_branch_fired = 1'b0;
    branch_on_resp = 1'b1;
    n = 0;
    while (!resp_branch_fired && n < 30) begin
      cycle();
      n++;
    end
    check("coresp_fired", 32'(resp_branch_fired), 32'd1);
    cycle();
    check("coresp_empty", 32'(bus.instr_valid), 32'd0);
    check("coresp_req", 32'(bus.imem_req), 32'd1);
    check("coresp_addr", bus.imem_addr, 32'h0000_0300);

    // PC wrap-around.
    lat_min = 1;
    lat_max = 1;
    force_branch = 1'b1;
    force_target = 32'hFFFF_FFF8;
    cycle();
    wait_req(20);
    wait_req(20);
    wait_req(20);
    check("wrap_addr", bus.imem_addr, 32'h0000_0000);
    repeat (10) cycle();

    // Reset during WAIT with a late response.
    force_branch = 1'b1;
    force_target = 32'h0000_4000;
    cycle();
    lat_min = 6;
    lat_max = 6;
    wait_req(20);
    force_reset_cycles = 2;
    cycle();
    cycle();
    lat_min = 1;
    lat_max = 1;
    popped_q.delete();
    wait_req(30);
    check("rst_late_addr", bus.imem_addr, RESET_PC);
    check("rst_late_empty", 32'(bus.instr_valid), 32'd0);
    n = 0;
    while (popped_q.size() < 1 && n < 20) begin
      cycle();
      n++;
    end
    check("rst_late_pop", 32'(popped_q.size()), 32'd1);
    if (popped_q.size() >= 1)
      check("rst_late_pc", popped_q[0], RESET_PC);

    // Randomized traffic: decoder stalls, branches, resets, variable latency.
    ready_mode = 2;
    branch_pct = 4;
    reset_pml = 3;
    lat_min = 1;
    lat_max = 5;
    repeat (3000) cycle();

    // Forward progress once the noise stops.
    ready_mode = 1;
    branch_pct = 0;
    reset_pml = 0;
    lat_max = 3;
    pop_count = 0;
    n = 0;
    while (pop_count < 8 && n < 200) begin
      cycle();
      n++;
    end
    check("progress", 32'(pop_count >= 8), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
